// File: rtl/fetch_sequencer_if.sv
// Fetch/IF-ID bundle between the fetch sequencer, instruction memory and decode.
// The sequencer takes the master side; memory, decode and redirect logic sit on the slave side.
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            intr;
  logic [15:0]     if_instr;
  logic [15:0]     if_imm;
  logic [PC_W-1:0] if_pc;
  logic            if_valid;
  logic            seq_busy;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  intr,
    output if_instr,
    output if_imm,
    output if_pc,
    output if_valid,
    output seq_busy
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output branch_taken,
    output branch_target,
    output intr,
    input  if_instr,
    input  if_imm,
    input  if_pc,
    input  if_valid,
    input  seq_busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, fills IF/ID, expands CALL/RET/RTI/interrupt into micro-ops and joins LDM words.
// Interrupt entry exists only when INTR_SEQ_EN is defined; otherwise intr is ignored.
module fetch_sequencer #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(2)
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_IMM   = 3'd1;
  localparam logic [2:0] ST_SEQ1  = 3'd2;
  localparam logic [2:0] ST_SEQ2  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam logic [4:0] OP_LDM        = 5'b11010;
  localparam logic [4:0] OP_CALL       = 5'b01101;
  localparam logic [4:0] OP_RET        = 5'b01110;
  localparam logic [4:0] OP_RTI        = 5'b01111;
  localparam logic [4:0] OP_PUSH_PC    = 5'b11111;
  localparam logic [4:0] OP_PUSH_FLAGS = 5'b11110;
  localparam logic [4:0] OP_POP_PC     = 5'b11100;
  localparam logic [4:0] OP_POP_FLAGS  = 5'b11101;
  localparam logic [4:0] OP_JMP_CALL   = 5'b11011;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifpc_q, ifpc_d;
  logic [15:0]     hold_q, hold_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     imm_q, imm_d;
  logic            valid_q, valid_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pc_inc;
  logic [4:0]      opc;
  logic [10:0]     low;
  logic            service;

  assign pc_inc  = pc_q + PC_W'(1);
  assign opc     = bus.imem_data[15:11];
  assign low     = bus.imem_data[10:0];
  assign service = (state_q == ST_FETCH) && pend_q && !bus.stall && !bus.branch_taken;

`ifdef INTR_SEQ_EN
  logic intr_q;
  logic intr_rise;

  assign intr_rise = bus.intr & ~intr_q;
  // A new edge arriving in the same cycle the old request is serviced must not be lost.
  assign pend_d    = (pend_q & ~service) | intr_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intr_q <= 1'b0;
    else        intr_q <= bus.intr;
  end
`else
  logic unused_intr;
  assign unused_intr = bus.intr;
  assign pend_d      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    if (!bus.stall) begin
      if (bus.branch_taken) begin
        pc_d    = bus.branch_target;
        instr_d = '0;
        imm_d   = '0;
        valid_d = 1'b0;
        state_d = ST_FETCH;
      end else begin
        imm_d   = '0;
        valid_d = 1'b1;
        case (state_q)
          ST_FETCH: begin
            if (service) begin
              // Interrupt entry: the fetched word is dropped and PC stays as the return address.
              instr_d = {OP_PUSH_PC, 11'd0};
              ifpc_d  = pc_q;
              hold_d  = {OP_PUSH_FLAGS, 11'd0};
              state_d = ST_SEQ2;
            end else begin
              case (opc)
                OP_LDM: begin
                  hold_d  = bus.imem_data;
                  pc_d    = pc_inc;
                  instr_d = '0;
                  valid_d = 1'b0;
                  state_d = ST_IMM;
                end
                OP_CALL: begin
                  instr_d = {OP_PUSH_PC, low};
                  ifpc_d  = pc_inc;
                  hold_d  = {OP_JMP_CALL, low};
                  state_d = ST_SEQ1;
                end
                OP_RET: begin
                  instr_d = {OP_POP_PC, low};
                  ifpc_d  = pc_inc;
                  state_d = ST_WAIT;
                end
                OP_RTI: begin
                  instr_d = {OP_POP_FLAGS, low};
                  ifpc_d  = pc_inc;
                  hold_d  = {OP_POP_PC, low};
                  state_d = ST_SEQ1;
                end
                default: begin
                  instr_d = bus.imem_data;
                  ifpc_d  = pc_inc;
                  pc_d    = pc_inc;
                end
              endcase
            end
          end
          ST_IMM: begin
            instr_d = hold_q;
            imm_d   = bus.imem_data;
            ifpc_d  = pc_inc;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
          ST_SEQ1: begin
            instr_d = hold_q;
            state_d = ST_WAIT;
          end
          ST_SEQ2: begin
            instr_d = hold_q;
            pc_d    = INT_VECTOR;
            state_d = ST_FETCH;
          end
          ST_WAIT: begin
            instr_d = '0;
            valid_d = 1'b0;
          end
          default: begin
            instr_d = '0;
            valid_d = 1'b0;
            state_d = ST_FETCH;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ifpc_q  <= '0;
      hold_q  <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifpc_q  <= ifpc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_imm    = imm_q;
  assign bus.if_pc     = ifpc_q;
  assign bus.if_valid  = valid_q;
  assign bus.seq_busy  = (state_q != ST_FETCH);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a queue-based reference model predicts every
// IF/ID word, and a negedge monitor pops and compares whenever the DUT presents a new valid word.
module tb_fetch_sequencer;
  localparam int              PC_W    = 32;
  localparam logic [PC_W-1:0] INT_VEC = 32'd2;
`ifdef INTR_SEQ_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  localparam logic [4:0] OP_LDM  = 5'b11010;
  localparam logic [4:0] OP_CALL = 5'b01101;
  localparam logic [4:0] OP_RET  = 5'b01110;
  localparam logic [4:0] OP_RTI  = 5'b01111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] mem [0:255];

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0), .INT_VECTOR(INT_VEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.imem_data = mem[bus.imem_addr[7:0]];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    bit          chk_pc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    bit          ldm;
    bit          then_wait;
    bit          then_vec;
  } step_t;

  exp_t  sb[$];
  step_t plan[$];
  logic [31:0] m_pc;
  bit m_wait, m_pend, m_prev, m_valid, m_busy, m_new, rise;
  bit chk_en = 1'b0;
  logic [15:0] last_instr = '0;
  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void add_exp(logic [15:0] i, logic [15:0] im, logic [31:0] p, bit c);
    exp_t e;
    e.instr = i; e.imm = im; e.pc = p; e.chk_pc = c;
    sb.push_back(e);
  endfunction

  function automatic void add_step(logic [15:0] i, bit l, bit w, bit v);
    step_t s;
    s.instr = i; s.ldm = l; s.then_wait = w; s.then_vec = v;
    plan.push_back(s);
  endfunction

  function automatic logic [15:0] rand_word();
    int k;
    logic [10:0] lo;
    k  = $urandom_range(0, 9);
    lo = 11'($urandom);
    case (k)
      0:       return {OP_LDM, lo};
      1:       return {OP_CALL, lo};
      2:       return {OP_RET, lo};
      3:       return {OP_RTI, lo};
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: pending micro-ops live in a plan queue; WAIT is just "parked until redirected".
  initial forever begin
    step_t s;
    logic [15:0] w;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pc = '0; plan.delete(); sb.delete();
      m_wait = 0; m_pend = 0; m_prev = 0; m_valid = 0; m_busy = 0; m_new = 0;
    end else begin
      rise   = bus.intr && !m_prev;
      m_prev = bus.intr;
      m_new  = !bus.stall;
      if (bus.stall) begin
        // everything holds
      end else if (bus.branch_taken) begin
        m_pc = bus.branch_target; plan.delete(); m_wait = 0; m_valid = 0;
      end else if (plan.size() > 0) begin
        s = plan.pop_front();
        if (s.ldm) begin
          add_exp(s.instr, mem[m_pc[7:0]], m_pc + 1, 1);
          m_pc = m_pc + 1;
        end else begin
          add_exp(s.instr, 16'h0, 32'h0, 0);
        end
        m_valid = 1;
        if (s.then_wait) m_wait = 1;
        if (s.then_vec)  m_pc = INT_VEC;
      end else if (m_wait) begin
        m_valid = 0;
      end else if (INTR_EN && m_pend) begin
        add_exp(16'hF800, 16'h0, m_pc, 1);
        add_step(16'hF000, 0, 0, 1);
        m_pend = 0; m_valid = 1;
      end else begin
        w = mem[m_pc[7:0]];
        m_valid = 1;
        case (w[15:11])
          OP_LDM: begin
            add_step(w, 1, 0, 0); m_pc = m_pc + 1; m_valid = 0;
          end
          OP_CALL: begin
            add_exp({5'b11111, w[10:0]}, 16'h0, m_pc + 1, 1);
            add_step({5'b11011, w[10:0]}, 0, 1, 0);
          end
          OP_RET: begin
            add_exp({5'b11100, w[10:0]}, 16'h0, 32'h0, 0); m_wait = 1;
          end
          OP_RTI: begin
            add_exp({5'b11101, w[10:0]}, 16'h0, 32'h0, 0);
            add_step({5'b11100, w[10:0]}, 0, 1, 0);
          end
          default: begin
            add_exp(w, 16'h0, m_pc + 1, 1); m_pc = m_pc + 1;
          end
        endcase
      end
      if (INTR_EN) m_pend = m_pend | rise;
      m_busy = (plan.size() > 0) || m_wait;
    end
  end

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && chk_en) begin
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
      chk("if_valid", 64'(bus.if_valid), 64'(m_valid));
      chk("seq_busy", 64'(bus.seq_busy), 64'(m_busy));
      if (bus.if_valid && m_new) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("if_instr", 64'(bus.if_instr), 64'(e.instr));
          chk("if_imm", 64'(bus.if_imm), 64'(e.imm));
          if (e.chk_pc) chk("if_pc", 64'(bus.if_pc), 64'(e.pc));
          last_instr = e.instr;
        end
      end else if (bus.if_valid) begin
        chk("stall_hold", 64'(bus.if_instr), 64'(last_instr));
      end else if (m_new && sb.size() > 0) begin
        sb.delete();
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, 64'(bus.if_valid), 64'd0);
    chk({tag, "_instr"}, 64'(bus.if_instr), 64'd0);
    chk({tag, "_imm"}, 64'(bus.if_imm), 64'd0);
    chk({tag, "_pc"}, 64'(bus.if_pc), 64'd0);
    chk({tag, "_busy"}, 64'(bus.seq_busy), 64'd0);
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    for (int i = 0; i < 10; i++) mem[i] = 16'h9800;
    mem[4]  = 16'hD000;
    mem[5]  = 16'h1234;
    mem[10] = 16'h6840;
    mem[64] = 16'h7800;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.intr = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    chk("first_instr", 64'(bus.if_instr), 64'h9800);
    chk("first_pc", 64'(bus.if_pc), 64'd1);
    chk("first_valid", 64'(bus.if_valid), 64'd1);

    // ADDs, LDM at 4, ADDs, CALL at 10 then parked; redirect into RTI at 0x40
    repeat (14) @(posedge clk);
    #1 bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    @(posedge clk); #1 bus.branch_taken = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.stall        = ($urandom_range(0, 99) < 15);
      bus.branch_taken = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 9))
        0:       bus.branch_target = 32'hFFFF_FFFE;
        1:       bus.branch_target = 32'h40;
        default: bus.branch_target = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) < 6) bus.intr = ~bus.intr;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.intr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
